i2c_codec_responder: RTL and testbench

- I2C target (slave) that models the audio codec control port, the other end of our I2C master config path.
- Accepts the codec's write-only frame: device address, then two bytes carrying a 7-bit register number and 9-bit data. Stores the data into a 16 x 9-bit register file.
- Used as a bench/loopback target for the codec init sequence, and as a shadow copy of codec settings for on-FPGA logic (e.g. the active bit).
- Runs on the fast system clock and oversamples SCL/SDA; no logic is clocked by SCL.

---
 rtl/i2c_codec_responder_if.sv | 31 +++
 rtl/i2c_codec_responder.sv | 236 +++++++++++++++++++++++
 tb/tb_i2c_codec_responder.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/i2c_codec_responder_if.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_codec_responder_if
//  Description : Bus and register-file signals of the I2C codec control-port
//                target. The slave modport is the target's view; the master
//                modport is the view of the bus driver / register reader.
//  Revision    : 1.0 - initial release
// ============================================================================
interface i2c_codec_responder_if;
    logic       scl_in;     // SCL line level
    logic       sda_in;     // SDA line level
    logic       sda_oe;     // 1 = target pulls SDA low
    logic [3:0] rd_addr;    // register file read address
    logic [8:0] rd_data;    // regs[rd_addr]
    logic       wr_strobe;  // one-clk pulse per register commit
    logic [6:0] wr_reg;     // register number of last commit
    logic [8:0] wr_data;    // data of last commit
    logic       active;     // codec active bit, regs[9][0]
    logic       busy;       // transfer in progress

    modport slave (
        input  scl_in, sda_in, rd_addr,
        output sda_oe, rd_data, wr_strobe, wr_reg, wr_data, active, busy
    );

    modport master (
        output scl_in, sda_in, rd_addr,
        input  sda_oe, rd_data, wr_strobe, wr_reg, wr_data, active, busy
    );
endinterface
`default_nettype wire

// File: rtl/i2c_codec_responder.sv
`default_nettype none
// ============================================================================
//  Module      : i2c_codec_responder
//  Description : Write-only I2C target modelling an audio codec control port.
//                Frame: device address, then {reg[6:0], d[8]}, then d[7:0].
//                Data lands in a 16 x 9-bit register file. SCL/SDA are
//                oversampled on clk; nothing is clocked by SCL.
//  Revision    : 1.0 - initial release
// ============================================================================
module i2c_codec_responder #(
    parameter logic [6:0] DEVICE_ID   = 7'b0011010,
    parameter int         SYNC_STAGES = 2
) (
    input  wire logic           clk,
    input  wire logic           reset,
    i2c_codec_responder_if.slave bus
);

    // Synchronizer depth is clamped so a misconfigured value of 0/1 still
    // leaves a metastability-safe chain.
    localparam int c_STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_ADDR     = 3'd1,
        S_ADDR_ACK = 3'd2,
        S_BYTE1    = 3'd3,
        S_ACK1     = 3'd4,
        S_BYTE2    = 3'd5,
        S_ACK2     = 3'd6,
        S_IGNORE   = 3'd7
    } state_t;

    // ------------------------------------------------------------------
    // Input conditioning
    // ------------------------------------------------------------------
    logic [c_STAGES-1:0] scl_sync_q;
    logic [c_STAGES-1:0] sda_sync_q;
    logic                scl_hist_q;
    logic                sda_hist_q;

    // Synchronize SCL/SDA and keep one history sample for edge detection;
    // reset to the idle (pulled-up) level so no false edges appear.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            scl_sync_q <= '1;
            sda_sync_q <= '1;
            scl_hist_q <= 1'b1;
            sda_hist_q <= 1'b1;
        end else begin
            scl_sync_q <= {scl_sync_q[c_STAGES-2:0], bus.scl_in};
            sda_sync_q <= {sda_sync_q[c_STAGES-2:0], bus.sda_in};
            scl_hist_q <= scl_sync_q[c_STAGES-1];
            sda_hist_q <= sda_sync_q[c_STAGES-1];
        end
    end

    logic w_scl;
    logic w_sda;
    logic w_scl_rise;
    logic w_scl_fall;
    logic w_sda_fall;
    logic w_sda_rise;
    logic w_start;
    logic w_stop;

    assign w_scl      = scl_sync_q[c_STAGES-1];
    assign w_sda      = sda_sync_q[c_STAGES-1];
    assign w_scl_rise =  w_scl & ~scl_hist_q;
    assign w_scl_fall = ~w_scl &  scl_hist_q;
    assign w_sda_fall = ~w_sda &  sda_hist_q;
    assign w_sda_rise =  w_sda & ~sda_hist_q;
    assign w_start    = w_sda_fall & w_scl;
    assign w_stop     = w_sda_rise & w_scl;

    // ------------------------------------------------------------------
    // Protocol FSM
    // ------------------------------------------------------------------
    state_t      state_q,     state_d;
    logic [2:0]  bit_cnt_q,   bit_cnt_d;
    logic [7:0]  shift_q,     shift_d;
    logic        byte_full_q, byte_full_d;   // 8 bits sampled, awaiting scl_fall
    logic [6:0]  reg_num_q,   reg_num_d;
    logic        d8_q,        d8_d;
    logic        sda_oe_q,    sda_oe_d;
    logic        w_commit;
    logic [8:0]  w_commit_data;

    assign w_commit_data = {d8_q, shift_q};

    // FSM state and datapath registers; sda_oe is a flop with async reset so
    // a reset mid-ACK releases the bus immediately.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            bit_cnt_q   <= 3'd0;
            shift_q     <= 8'd0;
            byte_full_q <= 1'b0;
            reg_num_q   <= 7'd0;
            d8_q        <= 1'b0;
            sda_oe_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_cnt_q   <= bit_cnt_d;
            shift_q     <= shift_d;
            byte_full_q <= byte_full_d;
            reg_num_q   <= reg_num_d;
            d8_q        <= d8_d;
            sda_oe_q    <= sda_oe_d;
        end
    end

    // Next-state logic: bus conditions override everything; bits are shifted
    // on scl_rise, and all SDA changes are made on scl_fall.
    always_comb begin
        state_d     = state_q;
        bit_cnt_d   = bit_cnt_q;
        shift_d     = shift_q;
        byte_full_d = byte_full_q;
        reg_num_d   = reg_num_q;
        d8_d        = d8_q;
        sda_oe_d    = sda_oe_q;
        w_commit    = 1'b0;

        if (w_start) begin
            // START or repeated START: drop any partial frame.
            state_d     = S_ADDR;
            bit_cnt_d   = 3'd0;
            byte_full_d = 1'b0;
            sda_oe_d    = 1'b0;
        end else if (w_stop) begin
            state_d     = S_IDLE;
            bit_cnt_d   = 3'd0;
            byte_full_d = 1'b0;
            sda_oe_d    = 1'b0;
        end else begin
            case (state_q)
                S_ADDR, S_BYTE1, S_BYTE2: begin
                    if (w_scl_rise && !byte_full_q) begin
                        shift_d   = {shift_q[6:0], w_sda};
                        bit_cnt_d = bit_cnt_q + 3'd1;
                        if (bit_cnt_q == 3'd7) begin
                            byte_full_d = 1'b1;
                        end
                    end else if (w_scl_fall && byte_full_q) begin
                        byte_full_d = 1'b0;
                        if (state_q == S_ADDR) begin
                            if ((shift_q[7:1] == DEVICE_ID) && !shift_q[0]) begin
                                sda_oe_d = 1'b1;
                                state_d  = S_ADDR_ACK;
                            end else begin
                                state_d  = S_IGNORE;
                            end
                        end else if (state_q == S_BYTE1) begin
                            reg_num_d = shift_q[7:1];
                            d8_d      = shift_q[0];
                            sda_oe_d  = 1'b1;
                            state_d   = S_ACK1;
                        end else begin
                            sda_oe_d  = 1'b1;
                            state_d   = S_ACK2;
                            w_commit  = 1'b1;
                        end
                    end
                end
                S_ADDR_ACK: begin
                    if (w_scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = S_BYTE1;
                    end
                end
                S_ACK1: begin
                    if (w_scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = S_BYTE2;
                    end
                end
                S_ACK2: begin
                    // Codec frames are exactly two data bytes; extras are NACKed.
                    if (w_scl_fall) begin
                        sda_oe_d = 1'b0;
                        state_d  = S_IGNORE;
                    end
                end
                default: begin
                    // S_IDLE and S_IGNORE: wait for START/STOP with SDA released.
                    sda_oe_d = 1'b0;
                end
            endcase
        end
    end

    // ------------------------------------------------------------------
    // Register file and commit reporting
    // ------------------------------------------------------------------
    logic [15:0][8:0] regs_q;
    logic             wr_strobe_q;
    logic [6:0]       wr_reg_q;
    logic [8:0]       wr_data_q;

    // Commit on the BYTE2 ACK: reg 15 is the codec soft reset and clears the
    // whole file; reg numbers above 15 are accepted but not stored.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            regs_q      <= '0;
            wr_strobe_q <= 1'b0;
            wr_reg_q    <= 7'd0;
            wr_data_q   <= 9'd0;
        end else begin
            wr_strobe_q <= 1'b0;
            if (w_commit) begin
                if (reg_num_q == 7'd15) begin
                    regs_q      <= '0;
                    wr_strobe_q <= 1'b1;
                    wr_reg_q    <= reg_num_q;
                    wr_data_q   <= w_commit_data;
                end else if (reg_num_q < 7'd15) begin
                    regs_q[reg_num_q[3:0]] <= w_commit_data;
                    wr_strobe_q            <= 1'b1;
                    wr_reg_q               <= reg_num_q;
                    wr_data_q              <= w_commit_data;
                end
            end
        end
    end

    assign bus.sda_oe    = sda_oe_q;
    assign bus.rd_data   = regs_q[bus.rd_addr];
    assign bus.wr_strobe = wr_strobe_q;
    assign bus.wr_reg    = wr_reg_q;
    assign bus.wr_data   = wr_data_q;
    assign bus.active    = regs_q[9][0];
    assign bus.busy      = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_i2c_codec_responder.sv
`default_nettype none
// ============================================================================
//  Module      : tb_i2c_codec_responder
//  Description : Self-checking bench for i2c_codec_responder. Bit-banged I2C
//                master, reference register model, commit scoreboard.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_i2c_codec_responder;

    localparam int Q = 8;   // clk cycles per quarter SCL period

    logic clk   = 1'b0;
    logic reset = 1'b1;
    logic m_scl = 1'b1;
    logic m_sda = 1'b1;

    always #5 clk = ~clk;

    i2c_codec_responder_if bus();

    // Open-drain wired-AND of master and target on SDA.
    assign bus.scl_in = m_scl;
    assign bus.sda_in = m_sda & ~bus.sda_oe;

    i2c_codec_responder #(
        .DEVICE_ID   (7'b0011010),
        .SYNC_STAGES (2)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [7:0] addr;
        logic [6:0] rnum;
        logic [8:0] data;
        logic [2:0] exp_ack;     // {addr, byte1, byte2}
        logic       exp_commit;
    } vec_t;

    typedef struct {
        logic [6:0] r;
        logic [8:0] d;
    } sb_t;

    vec_t       vecs[8];
    sb_t        sb_q[$];
    logic [8:0] model[16];

    int   n_checks = 0;
    int   n_fail   = 0;
    int   viol     = 0;
    logic prev_scl = 1'b1;
    logic prev_oe  = 1'b0;
    logic oe_seen  = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // SDA driven by the target must not move while SCL is high.
    always @(negedge clk) begin
        if (!reset && m_scl && prev_scl && (bus.sda_oe !== prev_oe)) viol++;
        prev_scl = m_scl;
        prev_oe  = bus.sda_oe;
        if (bus.sda_oe === 1'b1) oe_seen = 1'b1;
    end

    // Scoreboard: every strobe must match the oldest expected commit.
    always @(negedge clk) begin
        sb_t e;
        if (bus.wr_strobe === 1'b1) begin
            if (sb_q.size() == 0) begin
                check("unexpected_strobe", 32'd1, 32'd0);
            end else begin
                e = sb_q.pop_front();
                check("sb_wr_reg",  {25'd0, bus.wr_reg},  {25'd0, e.r});
                check("sb_wr_data", {23'd0, bus.wr_data}, {23'd0, e.d});
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic wait_clk(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic i2c_start();
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic i2c_stop();
        m_sda = 1'b0; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        m_sda = 1'b1; wait_clk(Q);
    endtask

    task automatic send_bit(input logic b);
        m_sda = b;    wait_clk(Q);
        m_scl = 1'b1; wait_clk(2*Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        for (int i = 7; i >= 0; i--) send_bit(b[i]);
        m_sda = 1'b1; wait_clk(Q);
        m_scl = 1'b1; wait_clk(Q);
        ack = ~bus.sda_in;
        wait_clk(Q);
        m_scl = 1'b0; wait_clk(Q);
    endtask

    task automatic expect_commit(input logic [6:0] r, input logic [8:0] d);
        sb_t e;
        e.r = r;
        e.d = d;
        sb_q.push_back(e);
        if (r == 7'd15) begin
            for (int i = 0; i < 16; i++) model[i] = 9'd0;
        end else if (r < 7'd15) begin
            model[r[3:0]] = d;
        end
    endtask

    task automatic check_regs(input string name);
        for (int i = 0; i < 16; i++) begin
            bus.rd_addr = i[3:0];
            #1;
            check(name, {23'd0, bus.rd_data}, {23'd0, model[i]});
        end
    endtask

    task automatic run_vec(input vec_t v);
        logic a0, a1, a2;
        oe_seen = 1'b0;
        if (v.exp_commit) expect_commit(v.rnum, v.data);
        i2c_start();
        check("busy_in_frame", {31'd0, bus.busy}, 32'd1);
        send_byte(v.addr, a0);
        send_byte({v.rnum, v.data[8]}, a1);
        send_byte(v.data[7:0], a2);
        i2c_stop();
        check("ack_addr",  {31'd0, a0}, {31'd0, v.exp_ack[2]});
        check("ack_byte1", {31'd0, a1}, {31'd0, v.exp_ack[1]});
        check("ack_byte2", {31'd0, a2}, {31'd0, v.exp_ack[0]});
        if (v.exp_ack == 3'b000) check("nack_oe_idle", {31'd0, oe_seen}, 32'd0);
        check("busy_after_stop", {31'd0, bus.busy}, 32'd0);
        check("active", {31'd0, bus.active}, {31'd0, model[9][0]});
    endtask

    initial begin
        logic a0, a1, a2, a3;
        vec_t v;

        vecs[0] = '{8'h34, 7'd6,  9'h000, 3'b111, 1'b1};
        vecs[1] = '{8'h34, 7'd0,  9'h017, 3'b111, 1'b1};
        vecs[2] = '{8'h34, 7'd7,  9'h04A, 3'b111, 1'b1};
        vecs[3] = '{8'h34, 7'd9,  9'h001, 3'b111, 1'b1};
        vecs[4] = '{8'h36, 7'd3,  9'h1FF, 3'b000, 1'b0};  // wrong ID
        vecs[5] = '{8'h35, 7'd3,  9'h1FF, 3'b000, 1'b0};  // read request
        vecs[6] = '{8'h34, 7'd20, 9'h155, 3'b111, 1'b0};  // reg out of range
        vecs[7] = '{8'h34, 7'd14, 9'h1AB, 3'b111, 1'b1};  // highest storable reg
        for (int i = 0; i < 16; i++) model[i] = 9'd0;
        bus.rd_addr = 4'd0;

        // Reset state
        wait_clk(5);
        reset = 1'b0;
        wait_clk(2*Q);
        check("rst_sda_oe",    {31'd0, bus.sda_oe},    32'd0);
        check("rst_wr_strobe", {31'd0, bus.wr_strobe}, 32'd0);
        check("rst_busy",      {31'd0, bus.busy},      32'd0);
        check("rst_wr_reg",    {25'd0, bus.wr_reg},    32'd0);
        check("rst_wr_data",   {23'd0, bus.wr_data},   32'd0);
        check("rst_active",    {31'd0, bus.active},    32'd0);
        check_regs("rst_regs");

        // Table of complete frames
        for (int i = 0; i < 8; i++) run_vec(vecs[i]);
        check_regs("table_regs");

        // STOP right after BYTE1: nothing committed
        i2c_start();
        send_byte(8'h34, a0);
        send_byte({7'd4, 1'b1}, a1);
        i2c_stop();
        check("stopb1_ack_addr", {31'd0, a0}, 32'd1);
        check("stopb1_ack_b1",   {31'd0, a1}, 32'd1);
        check("stopb1_busy",     {31'd0, bus.busy}, 32'd0);
        check_regs("stopb1_regs");

        // Repeated START mid-BYTE2, then a full write reg 4 = 2
        i2c_start();
        send_byte(8'h34, a0);
        send_byte({7'd4, 1'b0}, a1);
        for (int i = 0; i < 4; i++) send_bit(i[0]);
        expect_commit(7'd4, 9'h002);
        i2c_start();
        check("rstart_busy", {31'd0, bus.busy}, 32'd1);
        send_byte(8'h34, a0);
        send_byte({7'd4, 1'b0}, a1);
        send_byte(8'h02, a2);
        i2c_stop();
        check("rstart_ack_addr", {31'd0, a0}, 32'd1);
        check("rstart_ack_b1",   {31'd0, a1}, 32'd1);
        check("rstart_ack_b2",   {31'd0, a2}, 32'd1);
        check_regs("rstart_regs");

        // Codec reset via reg 15, plus an extra byte that must be NACKed
        expect_commit(7'd15, 9'h000);
        i2c_start();
        send_byte(8'h34, a0);
        send_byte({7'd15, 1'b0}, a1);
        send_byte(8'h00, a2);
        send_byte(8'hAA, a3);
        i2c_stop();
        check("r15_ack_addr", {31'd0, a0}, 32'd1);
        check("r15_ack_b1",   {31'd0, a1}, 32'd1);
        check("r15_ack_b2",   {31'd0, a2}, 32'd1);
        check("r15_nack_b3",  {31'd0, a3}, 32'd0);
        check("r15_active",   {31'd0, bus.active}, 32'd0);
        check_regs("r15_regs");

        // Reset while the target is driving the address ACK
        i2c_start();
        for (int i = 7; i >= 0; i--) send_bit(i == 2 || i == 4 || i == 5);
        m_sda = 1'b1;
        wait_clk(Q);
        check("pre_reset_oe", {31'd0, bus.sda_oe}, 32'd1);
        reset = 1'b1;
        #1;
        check("async_reset_oe",   {31'd0, bus.sda_oe}, 32'd0);
        check("async_reset_busy", {31'd0, bus.busy},   32'd0);
        for (int i = 0; i < 16; i++) model[i] = 9'd0;
        wait_clk(4);
        m_scl = 1'b1;
        m_sda = 1'b1;
        wait_clk(2);
        reset = 1'b0;
        wait_clk(2*Q);
        v = '{8'h34, 7'd9, 9'h001, 3'b111, 1'b1};
        run_vec(v);
        check_regs("post_reset_regs");

        check("sda_stable_scl_high", viol, 32'd0);
        check("sb_empty", sb_q.size(), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
